// File: rtl/ctrl_decode_stage_pkg.sv
// ctrl_pkg: shared definitions for the ID-stage control decoder.
//   - opcode / funct constants for the supported instruction set
//   - ALU_OP, MEM_TO_REG and BRANCH_TYPE encodings
//   - ctrl_bundle_t: the control fields carried in the ID/EX register
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLT   = 6'd6;
  localparam logic [5:0] OP_BLE   = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LI    = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNCT_JR = 6'd8;

  typedef enum logic [2:0] {
    ALU_RTYPE  = 3'b000,
    ALU_BRANCH = 3'b001,
    ALU_BNE    = 3'b010,
    ALU_ADD    = 3'b011,
    ALU_OR     = 3'b101,
    ALU_LI     = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    M2R_ALU = 2'b00,
    M2R_MEM = 2'b01,
    M2R_IMM = 2'b10,
    M2R_PC4 = 2'b11
  } mem_to_reg_e;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BLE = 2'b01,
    BR_BLT = 2'b10,
    BR_BNE = 2'b11
  } branch_type_e;

  typedef struct packed {
    logic         branch;
    logic         jump;
    logic         jr;
    logic         mem_read;
    logic         mem_write;
    logic         alu_src;
    logic         reg_write;
    branch_type_e branch_type;
    mem_to_reg_e  mem_to_reg;
    alu_op_e      alu_op;
    logic         illegal;
  } ctrl_bundle_t;

  // All-zero bundle; every enum field has a zero-valued member.
  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// ctrl_decode_stage_if: IF/ID-side inputs and ID/EX control outputs of the
// decode stage.
//   master: the surrounding pipeline (drives instr/valid/flush, observes outputs)
//   slave : the decode stage itself
interface ctrl_decode_stage_if #(
  parameter int ALU_OP_W   = 3,
  parameter int REG_ADDR_W = 5
);
  logic [31:0]           instr_i;
  logic                  valid_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  ex_valid_o;
  logic                  ex_branch_o;
  logic                  ex_jump_o;
  logic                  ex_jr_o;
  logic                  ex_mem_read_o;
  logic                  ex_mem_write_o;
  logic                  ex_alu_src_o;
  logic                  ex_reg_write_o;
  logic [1:0]            ex_branch_type_o;
  logic [1:0]            ex_mem_to_reg_o;
  logic [ALU_OP_W-1:0]   ex_alu_op_o;
  logic [REG_ADDR_W-1:0] ex_dst_o;
  logic                  ex_illegal_o;

  modport master (
    output instr_i, valid_i, flush_i,
    input  stall_o, ex_valid_o, ex_branch_o, ex_jump_o, ex_jr_o,
           ex_mem_read_o, ex_mem_write_o, ex_alu_src_o, ex_reg_write_o,
           ex_branch_type_o, ex_mem_to_reg_o, ex_alu_op_o, ex_dst_o,
           ex_illegal_o
  );

  modport slave (
    input  instr_i, valid_i, flush_i,
    output stall_o, ex_valid_o, ex_branch_o, ex_jump_o, ex_jr_o,
           ex_mem_read_o, ex_mem_write_o, ex_alu_src_o, ex_reg_write_o,
           ex_branch_type_o, ex_mem_to_reg_o, ex_alu_op_o, ex_dst_o,
           ex_illegal_o
  );
endinterface

// File: rtl/ctrl_decode_stage_comb.sv
// ctrl_decode_comb: purely combinational opcode/funct decoder.
//   opcode  in  6  instr[31:26]
//   funct   in  6  instr[5:0]
//   ctrl    out    decoded control bundle
//   use_rs  out 1  instruction reads rs
//   use_rt  out 1  instruction reads rt
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output ctrl_bundle_t ctrl,
  output logic         use_rs,
  output logic         use_rt
);

  // Unknown opcodes only raise illegal; the top still marks them valid.
  always_comb begin
    ctrl   = CTRL_BUBBLE;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        ctrl.alu_op = ALU_RTYPE;
        if (funct == FUNCT_JR) begin
          ctrl.jump = 1'b1;
          ctrl.jr   = 1'b1;
        end else begin
          ctrl.reg_write = 1'b1;
        end
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC4;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BLE: begin
        use_rs      = 1'b1;
        use_rt      = 1'b1;
        ctrl.branch = 1'b1;
        ctrl.alu_op = (opcode == OP_BNE) ? ALU_BNE : ALU_BRANCH;
        case (opcode)
          OP_BNE:  ctrl.branch_type = BR_BNE;
          OP_BLT:  ctrl.branch_type = BR_BLT;
          OP_BLE:  ctrl.branch_type = BR_BLE;
          default: ctrl.branch_type = BR_BEQ;
        endcase
      end
      OP_ADDI, OP_ORI: begin
        use_rs         = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      OP_LI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_IMM;
        ctrl.alu_op     = ALU_LI;
      end
      OP_LW: begin
        use_rs          = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MEM;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        use_rs         = 1'b1;
        use_rt         = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered ID stage control.
//   clk_i  in   clock, rising edge
//   rst_i  in   synchronous active-high reset
//   bus    slave port of ctrl_decode_stage_if (IF/ID inputs, stall_o, ex_*)
// Decodes the IF/ID instruction, resolves the destination register, detects
// load-use hazards and holds the ID/EX control register.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W   = 3,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31
) (
  input logic                clk_i,
  input logic                rst_i,
  ctrl_decode_stage_if.slave bus
);

  ctrl_bundle_t          dec_ctrl;
  logic                  use_rs;
  logic                  use_rt;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] dst;
  logic                  load_use;
  logic                  unused_shamt;

  ctrl_bundle_t          ex_ctrl;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic [2:0]            ex_alu_op_raw;

  ctrl_decode_comb u_decode (
    .opcode (bus.instr_i[31:26]),
    .funct  (bus.instr_i[5:0]),
    .ctrl   (dec_ctrl),
    .use_rs (use_rs),
    .use_rt (use_rt)
  );

  assign rs = REG_ADDR_W'(bus.instr_i[25:21]);
  assign rt = REG_ADDR_W'(bus.instr_i[20:16]);
  assign rd = REG_ADDR_W'(bus.instr_i[15:11]);
  assign unused_shamt = ^bus.instr_i[10:6];

  // Destination: rd for R-type, link register for JAL, rt for everything else.
  always_comb begin
    dst = rt;
    if (bus.instr_i[31:26] == OP_RTYPE) begin
      dst = rd;
    end else if (bus.instr_i[31:26] == OP_JAL) begin
      dst = REG_ADDR_W'(LINK_REG);
    end
  end

  // Load-use: the load in EX writes a register the ID instruction reads.
  // Only current ID/EX state and IF/ID inputs feed this, so there is no loop
  // through stall_o. A flushed ID instruction never stalls.
  assign load_use = ex_valid && ex_ctrl.mem_read && (ex_dst != '0) &&
                    ((use_rs && (rs == ex_dst)) || (use_rt && (rt == ex_dst))) &&
                    bus.valid_i && !bus.flush_i;

  assign bus.stall_o = load_use && !rst_i;

  // ID/EX register: reset beats flush beats stall; a bubble is all zeros.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_BUBBLE;
      ex_dst   <= '0;
    end else if (bus.flush_i || !bus.valid_i || load_use) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_BUBBLE;
      ex_dst   <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_ctrl  <= dec_ctrl;
      ex_dst   <= dec_ctrl.illegal ? '0 : dst;
    end
  end

  assign ex_alu_op_raw        = ex_ctrl.alu_op;
  assign bus.ex_valid_o       = ex_valid;
  assign bus.ex_branch_o      = ex_ctrl.branch;
  assign bus.ex_jump_o        = ex_ctrl.jump;
  assign bus.ex_jr_o          = ex_ctrl.jr;
  assign bus.ex_mem_read_o    = ex_ctrl.mem_read;
  assign bus.ex_mem_write_o   = ex_ctrl.mem_write;
  assign bus.ex_alu_src_o     = ex_ctrl.alu_src;
  assign bus.ex_reg_write_o   = ex_ctrl.reg_write;
  assign bus.ex_branch_type_o = ex_ctrl.branch_type;
  assign bus.ex_mem_to_reg_o  = ex_ctrl.mem_to_reg;
  assign bus.ex_alu_op_o      = ALU_OP_W'(ex_alu_op_raw);
  assign bus.ex_illegal_o     = ex_ctrl.illegal;
  assign bus.ex_dst_o         = ex_dst;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: directed-vector bench for ctrl_decode_stage.
// Expected ID/EX values are hand-written 21-bit control vectors.
module tb_ctrl_decode_stage;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ctrl_decode_stage_if #(.ALU_OP_W(3), .REG_ADDR_W(5)) bus ();

  ctrl_decode_stage #(.ALU_OP_W(3), .REG_ADDR_W(5), .LINK_REG(31)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Vector layout: {valid, branch, jump, jr, mem_read, mem_write, alu_src,
  //                 reg_write, branch_type[2], mem_to_reg[2], alu_op[3],
  //                 illegal, dst[5]}
  function automatic logic [31:0] ev(input logic v, br, j, jr, mr, mw, as, rw,
                                     input logic [1:0] bt, m2r,
                                     input logic [2:0] aop,
                                     input logic ill,
                                     input logic [4:0] dst);
    return {11'b0, v, br, j, jr, mr, mw, as, rw, bt, m2r, aop, ill, dst};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, rt, rd,
                                     input logic [5:0] funct);
    return {op, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] exVec();
    return {11'b0, bus.ex_valid_o, bus.ex_branch_o, bus.ex_jump_o, bus.ex_jr_o,
            bus.ex_mem_read_o, bus.ex_mem_write_o, bus.ex_alu_src_o,
            bus.ex_reg_write_o, bus.ex_branch_type_o, bus.ex_mem_to_reg_o,
            bus.ex_alu_op_o, bus.ex_illegal_o, bus.ex_dst_o};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive IF/ID inputs on the falling edge, then let combinational logic settle.
  task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                               input logic flush, input logic rst);
    @(negedge clk_i);
    bus.instr_i = instr;
    bus.valid_i = valid;
    bus.flush_i = flush;
    rst_i       = rst;
    #1;
  endtask

  task automatic checkStall(input string tag, input logic exp);
    checkOutput(tag, {31'b0, bus.stall_o}, {31'b0, exp});
  endtask

  task automatic checkEx(input string tag, input logic [31:0] exp);
    @(posedge clk_i);
    #1;
    checkOutput(tag, exVec(), exp);
  endtask

  logic [31:0] lw8, lw0, add_dep, exp_lw8, exp_add9, zero_v;

  initial begin
    bus.instr_i = '0;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;

    lw8      = mk(6'd35, 5'd1, 5'd8, 5'd0, 6'd4);
    lw0      = mk(6'd35, 5'd1, 5'd0, 5'd0, 6'd4);
    add_dep  = mk(6'd0, 5'd8, 5'd10, 5'd9, 6'd32);
    exp_lw8  = ev(1,0,0,0,1,0,1,1, 2'b00, 2'b01, 3'b011, 0, 5'd8);
    exp_add9 = ev(1,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b000, 0, 5'd9);
    zero_v   = '0;

    // Reset held two cycles with a live LW present.
    applyStimulus(lw8, 1, 0, 1);
    checkEx("reset_ex_c1", zero_v);
    checkStall("reset_stall_c1", 0);
    applyStimulus(lw8, 1, 0, 1);
    checkStall("reset_stall_c2", 0);
    checkEx("reset_ex_c2", zero_v);

    // Release: LW issues one edge later.
    applyStimulus(lw8, 1, 0, 0);
    checkStall("lw_no_stall", 0);
    checkEx("lw_issue", exp_lw8);

    // Dependent ADD: one stall cycle, one bubble, then ADD issues.
    applyStimulus(add_dep, 1, 0, 0);
    checkStall("loaduse_stall", 1);
    checkEx("loaduse_bubble", zero_v);
    applyStimulus(add_dep, 1, 0, 0);
    checkStall("loaduse_release", 0);
    checkEx("loaduse_add", exp_add9);

    // LW into $0 never stalls.
    applyStimulus(lw0, 1, 0, 0);
    checkEx("lw0_issue", ev(1,0,0,0,1,0,1,1, 2'b00, 2'b01, 3'b011, 0, 5'd0));
    applyStimulus(mk(6'd0, 5'd0, 5'd0, 5'd9, 6'd32), 1, 0, 0);
    checkStall("lw0_no_stall", 0);
    checkEx("lw0_add", exp_add9);

    // ADDI $9,$7 does not read $8.
    applyStimulus(lw8, 1, 0, 0);
    checkEx("lw8_b", exp_lw8);
    applyStimulus(mk(6'd8, 5'd7, 5'd9, 5'd0, 6'd1), 1, 0, 0);
    checkStall("addi_no_stall", 0);
    checkEx("addi", ev(1,0,0,0,0,0,1,1, 2'b00, 2'b00, 3'b011, 0, 5'd9));

    // LI ignores its rs field even when it names $8.
    applyStimulus(lw8, 1, 0, 0);
    checkEx("lw8_c", exp_lw8);
    applyStimulus(mk(6'd15, 5'd8, 5'd8, 5'd0, 6'd7), 1, 0, 0);
    checkStall("li_no_stall", 0);
    checkEx("li", ev(1,0,0,0,0,0,0,1, 2'b00, 2'b10, 3'b110, 0, 5'd8));

    // Flush in the load-use cycle: no stall, bubble, next instruction proceeds.
    applyStimulus(lw8, 1, 0, 0);
    checkEx("lw8_d", exp_lw8);
    applyStimulus(add_dep, 1, 1, 0);
    checkStall("flush_no_stall", 0);
    checkEx("flush_bubble", zero_v);
    applyStimulus(mk(6'd4, 5'd8, 5'd3, 5'd0, 6'd2), 1, 0, 0);
    checkStall("beq_after_flush", 0);
    checkEx("beq", ev(1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b001, 0, 5'd3));

    // SW reading the loaded register through rt stalls.
    applyStimulus(lw8, 1, 0, 0);
    checkEx("lw8_e", exp_lw8);
    applyStimulus(mk(6'd43, 5'd2, 5'd8, 5'd0, 6'd0), 1, 0, 0);
    checkStall("sw_rt_stall", 1);
    checkEx("sw_bubble", zero_v);
    applyStimulus(mk(6'd43, 5'd2, 5'd8, 5'd0, 6'd0), 1, 0, 0);
    checkEx("sw", ev(1,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b011, 0, 5'd8));

    // Remaining opcodes.
    applyStimulus(mk(6'd3, 5'd4, 5'd5, 5'd6, 6'd0), 1, 0, 0);
    checkEx("jal", ev(1,0,1,0,0,0,0,1, 2'b00, 2'b11, 3'b000, 0, 5'd31));
    applyStimulus(mk(6'd0, 5'd31, 5'd0, 5'd0, 6'd8), 1, 0, 0);
    checkEx("jr", ev(1,0,1,1,0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 5'd0));
    applyStimulus(mk(6'd63, 5'd4, 5'd5, 5'd6, 6'd8), 1, 0, 0);
    checkEx("illegal", ev(1,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1, 5'd0));
    applyStimulus(mk(6'd2, 5'd0, 5'd0, 5'd0, 6'd0), 1, 0, 0);
    checkEx("j", ev(1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 5'd0));
    applyStimulus(mk(6'd5, 5'd1, 5'd2, 5'd0, 6'd0), 1, 0, 0);
    checkEx("bne", ev(1,1,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 5'd2));
    applyStimulus(mk(6'd6, 5'd1, 5'd3, 5'd0, 6'd0), 1, 0, 0);
    checkEx("blt", ev(1,1,0,0,0,0,0,0, 2'b10, 2'b00, 3'b001, 0, 5'd3));
    applyStimulus(mk(6'd7, 5'd1, 5'd4, 5'd0, 6'd0), 1, 0, 0);
    checkEx("ble", ev(1,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'b001, 0, 5'd4));
    applyStimulus(mk(6'd13, 5'd1, 5'd12, 5'd0, 6'd0), 1, 0, 0);
    checkEx("ori", ev(1,0,0,0,0,0,1,1, 2'b00, 2'b00, 3'b101, 0, 5'd12));

    // valid_i low loads a bubble.
    applyStimulus(mk(6'd13, 5'd1, 5'd12, 5'd0, 6'd0), 0, 0, 0);
    checkEx("invalid_bubble", zero_v);

    // Reset during a load-use stall.
    applyStimulus(lw8, 1, 0, 0);
    checkEx("lw8_f", exp_lw8);
    applyStimulus(add_dep, 1, 0, 1);
    checkStall("rst_mid_stall", 0);
    checkEx("rst_mid_bubble", zero_v);
    applyStimulus(add_dep, 1, 0, 0);
    checkStall("post_rst_stall", 0);
    checkEx("post_rst_add", exp_add9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
